// File: rtl/counter_pkg.sv
// Shared constants and helpers for the 74xx-style counter family.
package counter_pkg;

   localparam int MODE_BINARY = 0;
   localparam int MODE_DECADE = 1;
   localparam int DIGIT_W     = 4;
   localparam int DIGIT_MAX   = 9;

   // Value a decade digit holds when it is about to carry (up) or borrow (down).
   function automatic logic [DIGIT_W-1:0] digit_terminal(input logic up);
      return up ? DIGIT_W'(DIGIT_MAX) : '0;
   endfunction

endpackage

// File: rtl/counter_digit.sv
// One counting stage: a BCD digit (decade mode) or the whole word (binary mode).
// Purely combinational; nxt_o is the value after one count when cin_i is set.
module counter_digit
   import counter_pkg::*;
#(
   parameter int W      = DIGIT_W,
   parameter int DECADE = MODE_BINARY
) (
   input  logic [W-1:0] val_i,
   input  logic         cin_i,
   input  logic         up_i,
   output logic [W-1:0] nxt_o,
   output logic         cout_o,
   output logic         term_o
);

   if (DECADE == MODE_DECADE) begin : g_bcd
      always_comb begin
         nxt_o  = val_i;
         cout_o = 1'b0;
         term_o = (val_i == digit_terminal(up_i));
         if (cin_i) begin
            if (up_i) begin
               // 9 and the invalid codes A-F all roll to 0 with a carry.
               if (val_i < W'(DIGIT_MAX)) begin
                  nxt_o = val_i + W'(1);
               end else begin
                  nxt_o  = '0;
                  cout_o = 1'b1;
               end
            end else begin
               if (val_i == '0) begin
                  nxt_o  = W'(DIGIT_MAX);
                  cout_o = 1'b1;
               end else if (val_i > W'(DIGIT_MAX)) begin
                  nxt_o = W'(DIGIT_MAX);
               end else begin
                  nxt_o = val_i - W'(1);
               end
            end
         end
      end
   end else begin : g_bin
      always_comb begin
         term_o = up_i ? (&val_i) : ~(|val_i);
         nxt_o  = val_i;
         cout_o = 1'b0;
         if (cin_i) begin
            nxt_o  = up_i ? (val_i + W'(1)) : (val_i - W'(1));
            cout_o = term_o;
         end
      end
   end

endmodule

// File: rtl/counter_161w.sv
// Parametrised 74xx160/161/162/163/191-style synchronous counter with load,
// ENP/ENT enables, up/down and combinational ripple-carry for cascading.
module counter_161w
   import counter_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int DECADE = MODE_BINARY
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sclr_n,
   input  logic             load_n,
   input  logic             enp,
   input  logic             ent,
   input  logic             up,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             rco
);

   localparam int SW   = (DECADE == MODE_DECADE) ? DIGIT_W : WIDTH;
   localparam int NDIG = WIDTH / SW;

   if ((DECADE == MODE_DECADE) && ((WIDTH % DIGIT_W) != 0)) begin : g_bad_width
      $error("counter_161w: decade mode needs WIDTH to be a multiple of 4");
   end

   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] cnt_nxt;
   logic [NDIG:0]    carry;
   logic [NDIG-1:0]  term;
   logic             terminal;

   // Chain always evaluates "what if we count"; enables only gate the register.
   assign carry[0] = 1'b1;

   for (genvar i = 0; i < NDIG; i++) begin : g_stage
      counter_digit #(
         .W      (SW),
         .DECADE (DECADE)
      ) u_digit (
         .val_i  (q_q[i*SW +: SW]),
         .cin_i  (carry[i]),
         .up_i   (up),
         .nxt_o  (cnt_nxt[i*SW +: SW]),
         .cout_o (carry[i+1]),
         .term_o (term[i])
      );
   end

   // Carry-out alone would also fire on invalid BCD digits counting up.
   assign terminal = carry[NDIG] & (&term);
   assign rco      = ent & terminal;
   assign q        = q_q;

   always_comb begin
      q_d = q_q;
      if (!sclr_n) begin
         q_d = '0;
      end else if (!load_n) begin
         q_d = d;
      end else if (enp && ent) begin
         q_d = cnt_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

endmodule

// File: tb/tb_counter_161w.sv
// Self-checking bench for counter_161w: vector tables applied through a
// scoreboard queue plus hand-written async-reset and rco sequences.
module tb_counter_161w;

   typedef struct packed {
      logic sclr_n;
      logic load_n;
      logic enp;
      logic ent;
      logic up;
   } ctl_t;

   typedef struct {
      int         dut;
      ctl_t       c;
      logic [7:0] d;
      logic [7:0] exp_q;
      logic       exp_rco;
      string      nm;
   } vec_t;

   typedef struct {
      int         dut;
      logic [7:0] exp_q;
      logic       exp_rco;
      string      nm;
   } exp_t;

   localparam ctl_t IDLE = '{sclr_n: 1'b1, load_n: 1'b1, enp: 1'b0, ent: 1'b0, up: 1'b1};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ctl_t ctl0 = IDLE, ctl1 = IDLE, ctl2 = IDLE, ctl3 = IDLE;
   logic [3:0] d0 = '0;
   logic [7:0] d1 = '0, d2 = '0, d3 = '0;
   logic [3:0] q0, q3lo, q3hi;
   logic [7:0] q1, q2;
   logic       rco0, rco1, rco2, rco3lo, rco3hi;

   int n_checks = 0;
   int n_fail   = 0;
   vec_t tbl[$];
   exp_t sb[$];

   counter_161w #(.WIDTH(4), .DECADE(0)) u_bin4 (
      .clk(clk), .rst_n(rst_n), .sclr_n(ctl0.sclr_n), .load_n(ctl0.load_n),
      .enp(ctl0.enp), .ent(ctl0.ent), .up(ctl0.up), .d(d0), .q(q0), .rco(rco0));

   counter_161w #(.WIDTH(8), .DECADE(1)) u_dec8 (
      .clk(clk), .rst_n(rst_n), .sclr_n(ctl1.sclr_n), .load_n(ctl1.load_n),
      .enp(ctl1.enp), .ent(ctl1.ent), .up(ctl1.up), .d(d1), .q(q1), .rco(rco1));

   counter_161w #(.WIDTH(8), .DECADE(0)) u_bin8 (
      .clk(clk), .rst_n(rst_n), .sclr_n(ctl2.sclr_n), .load_n(ctl2.load_n),
      .enp(ctl2.enp), .ent(ctl2.ent), .up(ctl2.up), .d(d2), .q(q2), .rco(rco2));

   counter_161w #(.WIDTH(4), .DECADE(0)) u_cas_lo (
      .clk(clk), .rst_n(rst_n), .sclr_n(ctl3.sclr_n), .load_n(ctl3.load_n),
      .enp(ctl3.enp), .ent(ctl3.ent), .up(ctl3.up), .d(d3[3:0]), .q(q3lo), .rco(rco3lo));

   counter_161w #(.WIDTH(4), .DECADE(0)) u_cas_hi (
      .clk(clk), .rst_n(rst_n), .sclr_n(ctl3.sclr_n), .load_n(ctl3.load_n),
      .enp(ctl3.enp), .ent(rco3lo), .up(ctl3.up), .d(d3[7:4]), .q(q3hi), .rco(rco3hi));

   function automatic logic [7:0] get_q(input int dut);
      case (dut)
         0:       return {4'h0, q0};
         1:       return q1;
         2:       return q2;
         default: return {q3hi, q3lo};
      endcase
   endfunction

   function automatic logic get_rco(input int dut);
      case (dut)
         0:       return rco0;
         1:       return rco1;
         2:       return rco2;
         default: return rco3hi;
      endcase
   endfunction

   task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input int dut, input ctl_t c, input logic [7:0] dd);
      case (dut)
         0:       begin ctl0 = c; d0 = dd[3:0]; end
         1:       begin ctl1 = c; d1 = dd; end
         2:       begin ctl2 = c; d2 = dd; end
         default: begin ctl3 = c; d3 = dd; end
      endcase
   endtask

   function automatic vec_t mk(input int dut, input logic s, input logic l, input logic p,
                               input logic t, input logic u, input logic [7:0] dd,
                               input logic [7:0] eq, input logic er, input string nm);
      vec_t v;
      v.dut = dut; v.c = '{sclr_n: s, load_n: l, enp: p, ent: t, up: u};
      v.d = dd; v.exp_q = eq; v.exp_rco = er; v.nm = nm;
      return v;
   endfunction

   task automatic apply_vec(input vec_t v);
      exp_t e;
      drive(v.dut, v.c, v.d);
      e.dut = v.dut; e.exp_q = v.exp_q; e.exp_rco = v.exp_rco; e.nm = v.nm;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check({e.nm, ".q"}, get_q(e.dut), e.exp_q);
      check({e.nm, ".rco"}, {7'h0, get_rco(e.dut)}, {7'h0, e.exp_rco});
   endtask

   task automatic run_tbl();
      foreach (tbl[i]) apply_vec(tbl[i]);
      tbl.delete();
   endtask

   initial begin
      logic [7:0] m;

      // Reset state, including rco re-evaluated from q=0 in down mode.
      #12;
      for (int i = 0; i < 4; i++) check($sformatf("reset_q%0d", i), get_q(i), 8'h00);
      check("reset_rco_up", {7'h0, rco0}, 8'h00);
      ctl0 = '{sclr_n: 1'b1, load_n: 1'b1, enp: 1'b0, ent: 1'b1, up: 1'b0};
      #1;
      check("reset_rco_down", {7'h0, rco0}, 8'h01);
      ctl0 = IDLE;
      rst_n = 1'b1;

      // Binary 4-bit free count through the wrap.
      m = 8'h00;
      for (int i = 0; i < 17; i++) begin
         m = (m + 8'h01) & 8'h0F;
         apply_vec(mk(0, 1, 1, 1, 1, 1, 8'h00, m, m == 8'h0F, $sformatf("count4_%0d", i)));
      end

      // Clear/load priority and enable gating.
      tbl.push_back(mk(0, 1, 0, 1, 1, 1, 8'h05, 8'h05, 0, "ld5"));
      tbl.push_back(mk(0, 0, 0, 1, 1, 1, 8'h09, 8'h00, 0, "sclr_over_load"));
      tbl.push_back(mk(0, 1, 0, 1, 1, 1, 8'h09, 8'h09, 0, "ld9"));
      tbl.push_back(mk(0, 1, 1, 0, 1, 1, 8'h00, 8'h09, 0, "enp0_hold"));
      tbl.push_back(mk(0, 1, 1, 1, 0, 1, 8'h00, 8'h09, 0, "ent0_hold"));
      tbl.push_back(mk(0, 1, 0, 0, 0, 1, 8'h0F, 8'h0F, 0, "ld15_ent0"));
      tbl.push_back(mk(0, 1, 1, 0, 1, 1, 8'h00, 8'h0F, 1, "rco_enp0"));
      tbl.push_back(mk(0, 1, 1, 1, 1, 1, 8'h00, 8'h00, 0, "wrap_up"));
      tbl.push_back(mk(0, 1, 1, 1, 1, 0, 8'h00, 8'h0F, 0, "wrap_down"));
      run_tbl();

      // Decade 8-bit: carries, wrap, invalid-digit correction.
      tbl.push_back(mk(1, 1, 0, 1, 1, 1, 8'h98, 8'h98, 0, "dec_ld98"));
      tbl.push_back(mk(1, 1, 1, 1, 1, 1, 8'h00, 8'h99, 1, "dec_99"));
      tbl.push_back(mk(1, 1, 1, 1, 1, 1, 8'h00, 8'h00, 0, "dec_wrap_up"));
      tbl.push_back(mk(1, 1, 0, 1, 1, 1, 8'h0C, 8'h0C, 0, "dec_ld0C"));
      tbl.push_back(mk(1, 1, 1, 1, 1, 1, 8'h00, 8'h10, 0, "dec_fix_0C"));
      tbl.push_back(mk(1, 1, 0, 1, 1, 0, 8'h00, 8'h00, 1, "dec_ld00_down"));
      tbl.push_back(mk(1, 1, 1, 1, 1, 0, 8'h00, 8'h99, 0, "dec_wrap_down"));
      tbl.push_back(mk(1, 1, 1, 1, 1, 0, 8'h00, 8'h98, 0, "dec_98_down"));
      tbl.push_back(mk(1, 1, 0, 1, 1, 1, 8'hAF, 8'hAF, 0, "dec_ldAF"));
      tbl.push_back(mk(1, 1, 1, 1, 1, 1, 8'h00, 8'h00, 0, "dec_fix_AF"));
      tbl.push_back(mk(1, 1, 0, 1, 1, 1, 8'h1F, 8'h1F, 0, "dec_ld1F"));
      tbl.push_back(mk(1, 1, 1, 1, 1, 1, 8'h00, 8'h20, 0, "dec_fix_1F"));
      tbl.push_back(mk(1, 1, 0, 1, 1, 0, 8'h0B, 8'h0B, 0, "dec_ld0B"));
      tbl.push_back(mk(1, 1, 1, 1, 1, 0, 8'h00, 8'h09, 0, "dec_fix_0B"));
      tbl.push_back(mk(1, 1, 0, 1, 1, 0, 8'h10, 8'h10, 0, "dec_ld10"));
      tbl.push_back(mk(1, 1, 1, 1, 1, 0, 8'h00, 8'h09, 0, "dec_borrow"));
      tbl.push_back(mk(1, 1, 1, 1, 1, 1, 8'h00, 8'h10, 0, "dec_carry"));
      run_tbl();

      // Async reset between edges on an 8-bit binary counter.
      apply_vec(mk(2, 1, 0, 1, 1, 1, 8'h37, 8'h37, 0, "b8_ld37"));
      ctl2 = '{sclr_n: 1'b1, load_n: 1'b1, enp: 1'b1, ent: 1'b1, up: 1'b1};
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_immediate", q2, 8'h00);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("arst_hold_%0d", i), q2, 8'h00);
      end
      ctl2.up = 1'b0;
      #1;
      check("arst_rco_down", {7'h0, rco2}, 8'h01);
      ctl2.up = 1'b1;
      #1;
      rst_n = 1'b1;
      apply_vec(mk(2, 1, 1, 1, 1, 1, 8'h00, 8'h01, 0, "arst_resume1"));
      apply_vec(mk(2, 1, 1, 1, 1, 1, 8'h00, 8'h02, 0, "arst_resume2"));

      // Two 4-bit stages cascaded through rco -> ent.
      tbl.push_back(mk(3, 1, 0, 1, 1, 1, 8'h0F, 8'h0F, 0, "cas_ld0F"));
      tbl.push_back(mk(3, 1, 1, 1, 1, 1, 8'h00, 8'h10, 0, "cas_up_10"));
      tbl.push_back(mk(3, 1, 1, 1, 1, 0, 8'h00, 8'h0F, 0, "cas_down_0F"));
      tbl.push_back(mk(3, 1, 0, 1, 1, 1, 8'hFF, 8'hFF, 1, "cas_ldFF"));
      tbl.push_back(mk(3, 1, 1, 1, 1, 1, 8'h00, 8'h00, 0, "cas_wrap"));
      tbl.push_back(mk(3, 1, 1, 0, 1, 0, 8'h00, 8'h00, 1, "cas_rco_down"));
      run_tbl();

      // Direction flip at q=0 moves rco with no clock edge.
      apply_vec(mk(0, 1, 0, 0, 1, 1, 8'h00, 8'h00, 0, "dir_ld0"));
      ctl0.load_n = 1'b1;
      @(negedge clk);
      ctl0.up = 1'b0;
      #1;
      check("dir_rco_down", {7'h0, rco0}, 8'h01);
      check("dir_q_kept", {4'h0, q0}, 8'h00);
      ctl0.up = 1'b1;
      #1;
      check("dir_rco_up", {7'h0, rco0}, 8'h00);

      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
